// File: rtl/instr_fetch_queue.sv
// IF-stage prefetch queue: sequential word fetch over req/ack, DEPTH-entry FIFO toward ID, flush on redirect.
// Head visible one cycle after ack (no bypass); ID stall holds the head. Optional perf counters: FETCH_PERF_CNT_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   id_valid,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc4,
    input  logic                   id_ready,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_KILL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_nxt;
    logic [31:0]     r_kill_pc;
    logic [31:0]     w_kill_pc_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    entry_t          r_fifo [DEPTH];
    entry_t          w_head;
    logic            w_req;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_space;
    logic [31:0]     w_redirect_pc;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_ack         = w_req & imem_ack;
    // Redirect voids both the in-flight data and any pop in the same cycle.
    assign w_push        = w_ack & (r_state == S_REQ) & ~redirect;
    assign w_pop         = id_valid & id_ready & ~redirect;
    assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    // Evaluated only when nothing remains outstanding, so count alone decides space.
    assign w_space       = (w_count_nxt < CW'(DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_kill_pc  <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_kill_pc  <= w_kill_pc_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_kill_pc_nxt  = r_kill_pc;
        if (redirect) begin
            if (w_req && !imem_ack) begin
                w_state_nxt   = S_KILL;
                w_kill_pc_nxt = w_redirect_pc;
            end else begin
                w_state_nxt    = S_REQ;
                w_fetch_pc_nxt = w_redirect_pc;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        w_state_nxt    = w_space ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_space) w_state_nxt = S_REQ;
                end
                S_KILL: begin
                    if (w_ack) begin
                        w_fetch_pc_nxt = r_kill_pc;
                        w_state_nxt    = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_req     = ((r_state == S_REQ) || (r_state == S_KILL)) && !rst;
        imem_req  = w_req;
        imem_addr = r_fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{instr: imem_rdata, pc4: r_fetch_pc + 32'd4};
        end
    end

    assign w_head      = r_fifo[r_rd_ptr];
    assign id_valid    = (r_count != '0);
    assign id_instr    = id_valid ? w_head.instr : 32'd0;
    assign id_pc4      = id_valid ? w_head.pc4   : 32'd0;
    assign queue_count = r_count;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_ack && (r_perf_fetch != 32'hFFFF_FFFF))            r_perf_fetch <= r_perf_fetch + 32'd1;
            if (redirect && (r_perf_flush != 32'hFFFF_FFFF))         r_perf_flush <= r_perf_flush + 32'd1;
            if (id_valid && !id_ready && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- IF-stage prefetch unit; sits directly upstream of the IF/ID pipeline register feeding the decode stage of the 5-stage pipelined MIPS core.
- Generates sequential word fetch addresses and issues them to instruction memory over a req/ack handshake.
- Buffers returned instructions, each with its PC+4, in a DEPTH-entry FIFO and presents them to ID with valid/ready.
- Flushes and restarts on a branch redirect from the MEM-stage branch resolution (beq_control / branch target).

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of fetch; bits [1:0] always 0
imem_ack  input  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
id_valid  output  1  head entry valid toward ID
id_instr  output  32  head instruction
id_pc4  output  32  head instruction address + 4
id_ready  input  1  ID consumes head this cycle (0 = stall)
redirect  input  1  branch taken; flush and refetch
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
queue_count  output  log2(DEPTH)+1  number of valid FIFO entries

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst has priority over every other input.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, queue_count=0.
  - FSM=REQ; fetch_pc=RESET_PC; read/write pointers 0.
- Memory handshake:
  - At most one outstanding request.
  - imem_req and imem_addr are held stable from assertion until the cycle imem_ack=1.
  - A zero-wait ack (in the same cycle req first rises) is legal.
  - imem_ack with imem_req=0 is ignored.
- Space rule: a new request is issued only if queue_count + (outstanding ? 1 : 0) < DEPTH, counted after this cycle's pop. An ack therefore never overflows the FIFO.
- FSM states:
  - REQ: imem_req=1, addr=fetch_pc.
    - On ack: push {imem_rdata, fetch_pc+4} and set fetch_pc += 4.
    - If there is still space, stay in REQ with the new address on the next cycle; otherwise go to HOLD.
  - HOLD: imem_req=0. Go to REQ in the cycle after space becomes available.
  - KILL: imem_req=1 with the stale address. On ack, discard the data, load fetch_pc from the latched redirect target, then go to REQ.
- Redirect:
  - On the next edge: queue flushed (queue_count=0, id_valid=0); any pop in that cycle is void.
  - If a request is outstanding and not acked this cycle: go to KILL and latch the target.
  - Otherwise: fetch_pc=redirect_pc and go to REQ.
  - If the ack coincides with redirect, the ack data is discarded.
  - A redirect while in KILL overwrites the latched target.
- FIFO:
  - Pop occurs when id_valid & id_ready.
  - Pushed data is visible at the head no earlier than the next cycle (no bypass).
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
  - When empty, id_instr and id_pc4 read 0.
  - id_ready while empty has no effect.
- Arithmetic: fetch_pc and pc4 are unsigned 32-bit; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: first request appears in the first cycle after rst deasserts. With zero-wait memory, the first id_valid follows one cycle later.
- Steady state: zero-wait memory with id_ready=1 sustains 1 instruction/cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds three outputs, each 32 bits, reset to 0, saturating at 32'hFFFF_FFFF.
  - perf_fetch_cnt: counts accepted acks, including discarded ones.
  - perf_flush_cnt: counts redirects.
  - perf_stall_cnt: counts cycles with id_valid=1 & id_ready=0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, zero-wait memory, id_ready=1 -> imem_addr 0,4,8,...; id_pc4 sequence 4,8,12 one per cycle after 2-cycle startup; queue_count never exceeds 1.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 acks; imem_req=0 while full; queue_count=4. Raise id_ready -> instructions 0..3 in order with no loss or duplication.
- Memory ack delay 3 cycles, redirect to 0x100 one cycle after req -> KILL: stale ack data not enqueued; next imem_addr=0x100; first id_pc4=0x104.
- Redirect to 0x203 coincident with ack and id_ready=1 -> ack data and popped head discarded; queue empty; next imem_addr=0x200.
- fetch_pc via redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc4 values 0xFFFF_FFFC, 0x0, 0x4.
- Assert rst mid-stream with a full queue and a request outstanding -> next cycle all outputs at reset values; a late ack from the old request is ignored; restart at RESET_PC.
